// File: rtl/cqc_wr_handler.sv
// CQC write handler: consumes WR_CQ_CXT packets from the CEU command demux,
// checks the head and the packet length, assembles the data beats into one
// CQ context and issues a single write to context storage.
// Malformed packets are drained and counted, never written.
module cqc_wr_handler #(
    parameter int         HEAD_WIDTH = 128,
    parameter int         DATA_WIDTH = 256,
    parameter int         CXT_BEATS  = 2,
    parameter int         ADDR_WIDTH = 32,
    parameter int         CQN_WIDTH  = 24,
    parameter int         CQ_NUM     = 65536,
    parameter logic [3:0] CMD_WR_CQC = 4'h3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cqc_req_valid,
    input  logic [HEAD_WIDTH-1:0]           cqc_req_head,
    input  logic                            cqc_req_last,
    input  logic [DATA_WIDTH-1:0]           cqc_req_data,
    output logic                            cqc_req_ready,
    input  logic [ADDR_WIDTH-1:0]           cxt_base,
    output logic                            cxt_wr_valid,
    output logic [ADDR_WIDTH-1:0]           cxt_wr_addr,
    output logic [DATA_WIDTH*CXT_BEATS-1:0] cxt_wr_data,
    input  logic                            cxt_wr_ready,
    output logic [15:0]                     wr_cnt,
    output logic [15:0]                     err_cnt
);

    localparam int CXT_BYTES = DATA_WIDTH * CXT_BEATS / 8;
    localparam int CXT_WIDTH = DATA_WIDTH * CXT_BEATS;
    localparam int BCNT_W    = $clog2(CXT_BEATS + 1);

    // One extra bit so CQ_NUM itself is representable next to a CQN field.
    localparam logic [CQN_WIDTH:0] CQ_LIMIT = (CQN_WIDTH + 1)'(CQ_NUM);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        ISSUE   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [BCNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic                    rst_done_q;
    logic                    valid_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [15:0]             wr_cnt_q;
    logic [15:0]             err_cnt_q;

    // Payload storage: CQN of the packet in flight and the assembled beats.
    logic [CQN_WIDTH-1:0]    cqn_q;
    logic [DATA_WIDTH-1:0]   slot_q [CXT_BEATS];
    logic [CXT_WIDTH-1:0]    cxt_flat;

    logic                    xfer;
    logic [3:0]              head_op;
    logic [CQN_WIDTH-1:0]    head_cqn;
    logic                    head_ok;
    logic [BCNT_W-1:0]       beat_cnt_inc;
    logic                    last_beat_slot;
    logic [BCNT_W-1:0]       wr_slot;
    logic                    slot_we;
    logic [CQN_WIDTH-1:0]    cqn_src;
    logic [ADDR_WIDTH-1:0]   issue_addr;
    logic                    enter_issue;
    logic                    err_inc;
    logic                    wr_inc;
    logic                    unused_head;

    // Only the opcode and the CQN field of the head carry meaning here.
    assign unused_head = ^cqc_req_head[HEAD_WIDTH-5:CQN_WIDTH];

    assign head_op  = cqc_req_head[HEAD_WIDTH-1 -: 4];
    assign head_cqn = cqc_req_head[CQN_WIDTH-1:0];
    assign head_ok  = (head_op == CMD_WR_CQC) && ({1'b0, head_cqn} < CQ_LIMIT);

    // Ready is a pure function of state; it stays low until the first edge
    // after reset release so no beat is taken while the block is settling.
    assign cqc_req_ready = rst_done_q && (state_q != ISSUE);
    assign xfer          = cqc_req_valid && cqc_req_ready;

    assign beat_cnt_inc   = beat_cnt_q + BCNT_W'(1);
    assign last_beat_slot = (beat_cnt_inc == BCNT_W'(CXT_BEATS));

    // The head beat always lands in slot 0; later beats follow beat_cnt.
    assign wr_slot = (state_q == IDLE) ? '0 : beat_cnt_q;
    assign slot_we = xfer && ((state_q == IDLE) || (state_q == COLLECT));

    // With single-beat contexts ISSUE is entered straight from IDLE, before
    // the CQN has been latched, so take it from the live head in that case.
    assign cqn_src     = (state_q == IDLE) ? head_cqn : cqn_q;
    assign issue_addr  = cxt_base + (ADDR_WIDTH'(cqn_src) * ADDR_WIDTH'(CXT_BYTES));
    assign enter_issue = (state_d == ISSUE) && (state_q != ISSUE);

    // Next-state, beat counting and counter-event decode.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        err_inc    = 1'b0;
        wr_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    beat_cnt_d = BCNT_W'(1);
                    if (!head_ok) begin
                        err_inc = 1'b1;
                        state_d = cqc_req_last ? IDLE : DRAIN;
                    end else if (cqc_req_last) begin
                        if (CXT_BEATS == 1) begin
                            state_d = ISSUE;
                        end else begin
                            // Head arrived alone: packet too short.
                            err_inc = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end

            COLLECT: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_inc;
                    if (last_beat_slot) begin
                        if (cqc_req_last) begin
                            state_d = ISSUE;
                        end else begin
                            // Context is full but the packet continues:
                            // discard what was assembled and drain the rest.
                            err_inc = 1'b1;
                            state_d = DRAIN;
                        end
                    end else if (cqc_req_last) begin
                        err_inc = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            DRAIN: begin
                if (xfer && cqc_req_last) begin
                    state_d = IDLE;
                end
            end

            ISSUE: begin
                if (cxt_wr_ready) begin
                    wr_inc  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            beat_cnt_d = '0;
        end
    end

    // Control state, write request and counters; cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            rst_done_q <= 1'b0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            wr_cnt_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            rst_done_q <= 1'b1;
            valid_q    <= (state_d == ISSUE);
            if (enter_issue) begin
                addr_q <= issue_addr;
            end
            if (wr_inc) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
            if (err_inc && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    // Payload capture; no reset needed because nothing reads it before a
    // full context has been written into it.
    always_ff @(posedge clk) begin
        if (xfer && (state_q == IDLE)) begin
            cqn_q <= head_cqn;
        end
        for (int i = 0; i < CXT_BEATS; i++) begin
            if (slot_we && (wr_slot == BCNT_W'(i))) begin
                slot_q[i] <= cqc_req_data;
            end
        end
    end

    // Flatten the slots into the context word, beat 0 in the LSBs.
    always_comb begin
        cxt_flat = '0;
        for (int i = 0; i < CXT_BEATS; i++) begin
            cxt_flat[i*DATA_WIDTH +: DATA_WIDTH] = slot_q[i];
        end
    end

    // Data is gated by valid so the output reads zero after reset without
    // having to clear the whole context buffer.
    assign cxt_wr_valid = valid_q;
    assign cxt_wr_addr  = addr_q;
    assign cxt_wr_data  = valid_q ? cxt_flat : '0;
    assign wr_cnt       = wr_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_cqc_wr_handler.sv
// Directed bench for cqc_wr_handler with a write scoreboard.
module tb_cqc_wr_handler;

    localparam int DW = 256;
    localparam int CB = 2;
    localparam int AW = 32;
    localparam int CW = DW * CB;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cqc_req_valid;
    logic [127:0]   cqc_req_head;
    logic           cqc_req_last;
    logic [DW-1:0]  cqc_req_data;
    logic           cqc_req_ready;
    logic [AW-1:0]  cxt_base;
    logic           cxt_wr_valid;
    logic [AW-1:0]  cxt_wr_addr;
    logic [CW-1:0]  cxt_wr_data;
    logic           cxt_wr_ready;
    logic [15:0]    wr_cnt;
    logic [15:0]    err_cnt;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] exp_addr_q [$];
    logic [CW-1:0] exp_data_q [$];

    always #5 clk = ~clk;

    cqc_wr_handler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cqc_req_valid (cqc_req_valid),
        .cqc_req_head  (cqc_req_head),
        .cqc_req_last  (cqc_req_last),
        .cqc_req_data  (cqc_req_data),
        .cqc_req_ready (cqc_req_ready),
        .cxt_base      (cxt_base),
        .cxt_wr_valid  (cxt_wr_valid),
        .cxt_wr_addr   (cxt_wr_addr),
        .cxt_wr_data   (cxt_wr_data),
        .cxt_wr_ready  (cxt_wr_ready),
        .wr_cnt        (wr_cnt),
        .err_cnt       (err_cnt)
    );

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mkhead(input logic [3:0] op, input logic [23:0] cqn);
        return {op, 100'd0, cqn};
    endfunction

    function automatic logic [DW-1:0] pat(input int i);
        logic [7:0] b;
        b = 8'(8'h11 * (i + 1));
        return {32{b}};
    endfunction

    // Scoreboard entry for a good 2-beat packet to the given CQN.
    task automatic expect_write(input logic [23:0] cqn);
        exp_addr_q.push_back(cxt_base + 32'(cqn) * 32'd64);
        exp_data_q.push_back({pat(1), pat(0)});
    endtask

    // Drive one beat starting at a negedge; returns at the negedge after it
    // transferred, with the number of cycles it had to wait for ready.
    task automatic beat(input logic [127:0] h, input logic [DW-1:0] d, input logic l,
                        output int waits);
        cqc_req_valid = 1'b1;
        cqc_req_head  = h;
        cqc_req_data  = d;
        cqc_req_last  = l;
        waits = 0;
        while (!cqc_req_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        @(negedge clk);
        cqc_req_valid = 1'b0;
        cqc_req_last  = 1'b0;
    endtask

    task automatic send_pkt(input logic [3:0] op, input logic [23:0] cqn, input int nb,
                            output int w0, output int wrest);
        int w;
        w0 = 0;
        wrest = 0;
        for (int i = 0; i < nb; i++) begin
            beat(mkhead(op, cqn), pat(i), (i == nb - 1), w);
            chk("beat_accept", (w < 50), 1);
            if (i == 0) w0 = w;
            else        wrest += w;
        end
    endtask

    // Write monitor: every accepted write must match the scoreboard head.
    always @(negedge clk) begin
        #2;
        if (rst_n && cxt_wr_valid && cxt_wr_ready) begin
            checks++;
            assert (exp_addr_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write: addr %0h with empty scoreboard", cxt_wr_addr);
            end
            if (exp_addr_q.size() != 0) begin
                chk("wr_addr", cxt_wr_addr, exp_addr_q.pop_front());
                chk("wr_data", cxt_wr_data, exp_data_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int wr;
        logic [AW-1:0] hold_addr;
        logic [CW-1:0] hold_data;

        rst_n         = 1'b0;
        cqc_req_valid = 1'b0;
        cqc_req_head  = '0;
        cqc_req_last  = 1'b0;
        cqc_req_data  = '0;
        cxt_base      = 32'h1000_0000;
        cxt_wr_ready  = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", cqc_req_ready, 0);
        chk("rst_valid", cxt_wr_valid, 0);
        chk("rst_addr", cxt_wr_addr, 0);
        chk("rst_data", cxt_wr_data, 0);
        chk("rst_wr_cnt", wr_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        chk("ready_before_rst_done", cqc_req_ready, 0);
        @(negedge clk);
        chk("ready_after_rst_done", cqc_req_ready, 1);

        // Good write, latency one cycle after the final beat
        expect_write(24'd5);
        send_pkt(4'h3, 24'd5, 2, w0, wr);
        chk("good_latency_valid", cxt_wr_valid, 1);
        chk("good_addr", cxt_wr_addr, 32'h1000_0140);
        chk("good_data", cxt_wr_data, {{32{8'h22}}, {32{8'h11}}});
        @(negedge clk);
        chk("good_valid_drop", cxt_wr_valid, 0);
        chk("good_wr_cnt", wr_cnt, 1);
        chk("good_err_cnt", err_cnt, 0);

        // Backpressure: write held for six cycles, request side stalled
        cxt_wr_ready = 1'b0;
        expect_write(24'd5);
        send_pkt(4'h3, 24'd5, 2, w0, wr);
        hold_addr = cxt_wr_addr;
        hold_data = cxt_wr_data;
        chk("bp_addr", hold_addr, 32'h1000_0140);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", cxt_wr_valid, 1);
            chk("bp_ready_low", cqc_req_ready, 0);
            chk("bp_addr_stable", cxt_wr_addr, hold_addr);
            chk("bp_data_stable", cxt_wr_data, hold_data);
            @(negedge clk);
        end
        chk("bp_valid_6th", cxt_wr_valid, 1);
        cxt_wr_ready = 1'b1;

        // Bad opcode right behind the accept; both beats drained
        send_pkt(4'h1, 24'd5, 2, w0, wr);
        chk("next_head_spacing", w0, 1);
        chk("badop_drain_no_stall", wr, 0);
        chk("bp_wr_cnt", wr_cnt, 2);
        chk("badop_err_cnt", err_cnt, 1);
        chk("badop_no_write", cxt_wr_valid, 0);

        // Good packet to CQN 0 lands at the table base
        expect_write(24'd0);
        send_pkt(4'h3, 24'd0, 2, w0, wr);
        chk("cqn0_addr", cxt_wr_addr, 32'h1000_0000);
        @(negedge clk);
        chk("cqn0_wr_cnt", wr_cnt, 3);

        // Length errors
        send_pkt(4'h3, 24'd5, 1, w0, wr);
        chk("short_no_write", cxt_wr_valid, 0);
        chk("short_err_cnt", err_cnt, 2);
        send_pkt(4'h3, 24'd5, 3, w0, wr);
        chk("long_drain_no_stall", wr, 0);
        chk("long_no_write", cxt_wr_valid, 0);
        chk("long_err_cnt", err_cnt, 3);
        expect_write(24'd9);
        send_pkt(4'h3, 24'd9, 2, w0, wr);
        chk("after_len_addr", cxt_wr_addr, 32'h1000_0240);
        @(negedge clk);
        chk("after_len_wr_cnt", wr_cnt, 4);

        // CQN range boundary
        send_pkt(4'h3, 24'd65536, 2, w0, wr);
        chk("cqn_oor_no_write", cxt_wr_valid, 0);
        chk("cqn_oor_err_cnt", err_cnt, 4);
        expect_write(24'd65535);
        send_pkt(4'h3, 24'd65535, 2, w0, wr);
        chk("cqn_max_addr", cxt_wr_addr, 32'h103F_FFC0);
        @(negedge clk);
        chk("cqn_max_wr_cnt", wr_cnt, 5);

        // Reset while a write is pending
        cxt_wr_ready = 1'b0;
        send_pkt(4'h3, 24'd3, 2, w0, wr);
        chk("pre_rst_valid", cxt_wr_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", cxt_wr_valid, 0);
        chk("midrst_ready", cqc_req_ready, 0);
        chk("midrst_wr_cnt", wr_cnt, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rerst_ready_low", cqc_req_ready, 0);
        @(negedge clk);
        chk("rerst_ready_high", cqc_req_ready, 1);
        cxt_wr_ready = 1'b1;
        expect_write(24'd3);
        send_pkt(4'h3, 24'd3, 2, w0, wr);
        chk("rerst_addr", cxt_wr_addr, 32'h1000_00C0);
        @(negedge clk);
        chk("rerst_wr_cnt", wr_cnt, 1);

        // err_cnt saturation
        for (int i = 0; i < 65535; i++) begin
            send_pkt(4'h1, 24'd0, 1, w0, wr);
        end
        chk("sat_err_full", err_cnt, 16'hFFFF);
        send_pkt(4'h1, 24'd0, 1, w0, wr);
        chk("sat_err_hold", err_cnt, 16'hFFFF);
        chk("sat_wr_cnt", wr_cnt, 1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_addr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
